debounce_edge: RTL and testbench

DEBOUNCE_EDGE -- requirements
Module: debounce_edge

---
 rtl/debounce_edge.sv | 149 ++++++++++++++
 tb/tb_debounce_edge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_edge.sv
`default_nettype none
// ============================================================================
// Module      : debounce_edge
// Description : Switch/button debouncer with edge detection.
//               A raw asynchronous level is brought into the clk domain by a
//               two-flop synchronizer. A four-state FSM then accepts a level
//               change only after STABLE_CYCLES consecutive agreeing samples.
//               On acceptance it emits a one-cycle rise or fall pulse and,
//               for rises only, advances an 8-bit wrapping edge counter.
// Ports       : clk      - sole clock, rising edge
//               rst      - asynchronous active-high reset
//               A        - raw bouncing input level
//               Y        - debounced level (registered)
//               rise     - one-cycle pulse on accepted 0->1 (registered)
//               fall     - one-cycle pulse on accepted 1->0 (registered)
//               busy     - high while a candidate change is being qualified
//               edge_cnt - count of accepted rising edges, wraps 255 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_edge #(
    parameter int STABLE_CYCLES = 10,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    output logic       Y,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [7:0] edge_cnt
);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    // Count value reached when the final qualifying sample is being checked.
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q, y_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;
    logic [7:0]       edge_cnt_q, edge_cnt_d;

    always_comb begin
        sync1_d    = A;
        sync2_d    = sync1_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        y_d        = y_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        edge_cnt_d = edge_cnt_q;

        case (state_q)
            ST_LOW: begin
                if (sync2_q) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = C_CNT_ONE;
                end
            end
            ST_WAIT_HIGH: begin
                // A mismatching sample is tested first so that a glitch on
                // the final qualifying sample aborts instead of accepting.
                if (!sync2_q) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == C_LAST_CNT) begin
                    state_d    = ST_HIGH;
                    cnt_d      = '0;
                    y_d        = 1'b1;
                    rise_d     = 1'b1;
                    edge_cnt_d = edge_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync2_q) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = C_CNT_ONE;
                end
            end
            ST_WAIT_LOW: begin
                if (sync2_q) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == C_LAST_CNT) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    y_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase

        // busy is registered from the next state so it tracks the state
        // register exactly.
        busy_d = (state_d == ST_WAIT_HIGH) || (state_d == ST_WAIT_LOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= ST_LOW;
            cnt_q      <= '0;
            y_q        <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            busy_q     <= 1'b0;
            edge_cnt_q <= 8'd0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            y_q        <= y_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            busy_q     <= busy_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign Y        = y_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign busy     = busy_q;
    assign edge_cnt = edge_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce_edge.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_edge
// Description : Self-checking bench for debounce_edge. Scenario tasks drive A
//               and push expected output snapshots, keyed by cycle number,
//               into a scoreboard queue; a negedge monitor pops and compares
//               them when that cycle is reached.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_debounce_edge;

    logic       clk = 1'b0;
    logic       rst;
    logic       A;
    logic       Y;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] edge_cnt;

    debounce_edge #(.STABLE_CYCLES(10), .CNT_W(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .Y        (Y),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy),
        .edge_cnt (edge_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      tag;
        logic       y;
        logic       r;
        logic       f;
        logic       b;
        logic [7:0] ec;
    } exp_t;

    exp_t       sb[$];
    int         cyc       = 0;
    int         t0        = 0;
    int         n_chk     = 0;
    int         n_pass    = 0;
    int         exp_rises = 0;
    int         exp_falls = 0;
    int         rise_seen = 0;
    int         fall_seen = 0;
    int         both_seen = 0;
    logic [7:0] ec_exp    = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    // Expected snapshot after edge k, where edge 0 is the first rising edge
    // after A was last set at cycle t0.
    task automatic expect_at(input int k, input string tag, input logic y, input logic r,
                             input logic f, input logic b, input logic [7:0] ec);
        exp_t e;
        e.cyc = t0 + 1 + k;
        e.tag = tag;
        e.y   = y;
        e.r   = r;
        e.f   = f;
        e.b   = b;
        e.ec  = ec;
        sb.push_back(e);
        if (r) exp_rises++;
        if (f) exp_falls++;
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                chk({sb[i].tag, "_y"},    Y,        sb[i].y);
                chk({sb[i].tag, "_rise"}, rise,     sb[i].r);
                chk({sb[i].tag, "_fall"}, fall,     sb[i].f);
                chk({sb[i].tag, "_busy"}, busy,     sb[i].b);
                chk({sb[i].tag, "_ecnt"}, edge_cnt, sb[i].ec);
                sb.delete(i);
            end
        end
        if (rise === 1'b1) rise_seen++;
        if (fall === 1'b1) fall_seen++;
        if (rise === 1'b1 && fall === 1'b1) both_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_y"},    Y,        0);
        chk({tag, "_rise"}, rise,     0);
        chk({tag, "_fall"}, fall,     0);
        chk({tag, "_busy"}, busy,     0);
        chk({tag, "_ecnt"}, edge_cnt, 0);
    endtask

    task automatic do_rise(input string tag);
        logic [7:0] prev;
        prev = ec_exp;
        ec_exp = ec_exp + 8'd1;
        t0 = cyc;
        A = 1'b1;
        expect_at(1,  {tag, "_e1"},  0, 0, 0, 0, prev);
        expect_at(2,  {tag, "_e2"},  0, 0, 0, 1, prev);
        expect_at(10, {tag, "_e10"}, 0, 0, 0, 1, prev);
        expect_at(11, {tag, "_e11"}, 1, 1, 0, 0, ec_exp);
        expect_at(12, {tag, "_e12"}, 1, 0, 0, 0, ec_exp);
        tick(13);
    endtask

    task automatic do_fall(input string tag);
        t0 = cyc;
        A = 1'b0;
        expect_at(2,  {tag, "_e2"},  1, 0, 0, 1, ec_exp);
        expect_at(10, {tag, "_e10"}, 1, 0, 0, 1, ec_exp);
        expect_at(11, {tag, "_e11"}, 0, 0, 1, 0, ec_exp);
        expect_at(12, {tag, "_e12"}, 0, 0, 0, 0, ec_exp);
        tick(13);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] prev;
        rst = 1'b1;
        A   = 1'b0;
        tick(3);
        chk_zero("por");
        rst = 1'b0;
        tick(2);

        // Clean rise then fall.
        do_rise("rise");
        do_fall("fall");

        // Bounce: 3-cycle pulses 1,0,1,0 then hold 1. FSM sees s=1 on
        // edges 2..4 and 8..10, s=0 on 5..7 and 11..13, steady 1 from 14.
        prev = ec_exp;
        ec_exp = ec_exp + 8'd1;
        t0 = cyc;
        expect_at(4,  "bnc_e4",  0, 0, 0, 1, prev);
        expect_at(6,  "bnc_e6",  0, 0, 0, 0, prev);
        expect_at(9,  "bnc_e9",  0, 0, 0, 1, prev);
        expect_at(12, "bnc_e12", 0, 0, 0, 0, prev);
        expect_at(22, "bnc_e22", 0, 0, 0, 1, prev);
        expect_at(23, "bnc_e23", 1, 1, 0, 0, ec_exp);
        expect_at(24, "bnc_e24", 1, 0, 0, 0, ec_exp);
        A = 1'b1; tick(3);
        A = 1'b0; tick(3);
        A = 1'b1; tick(3);
        A = 1'b0; tick(3);
        A = 1'b1; tick(13);
        do_fall("bnc_fall");

        // Glitch so that the 10th qualifying sample (edge 11) sees s=0.
        prev = ec_exp;
        ec_exp = ec_exp + 8'd1;
        t0 = cyc;
        A = 1'b1;
        expect_at(10, "gl_e10", 0, 0, 0, 1, prev);
        expect_at(11, "gl_e11", 0, 0, 0, 0, prev);
        expect_at(12, "gl_e12", 0, 0, 0, 1, prev);
        expect_at(20, "gl_e20", 0, 0, 0, 1, prev);
        expect_at(21, "gl_e21", 1, 1, 0, 0, ec_exp);
        expect_at(22, "gl_e22", 1, 0, 0, 0, ec_exp);
        tick(9);
        A = 1'b0; tick(1);
        A = 1'b1; tick(13);
        do_fall("gl_fall");

        // Reset in the middle of WAIT_HIGH, release with A still high.
        A = 1'b1;
        tick(5);
        #2 rst = 1'b1;
        #1 chk_zero("rst_mid");
        tick(2);
        rst = 1'b0;
        ec_exp = 8'd0;
        do_rise("rst_rel");
        do_fall("rst_rel_fall");

        // Wrap: 256 rises from reset.
        #2 rst = 1'b1;
        tick(2);
        rst = 1'b0;
        ec_exp = 8'd0;
        for (int i = 0; i < 256; i++) begin
            do_rise("wrap");
            if (i == 254) chk("wrap_ff", edge_cnt, 8'hFF);
            if (i == 255) chk("wrap_00", edge_cnt, 8'h00);
            do_fall("wrap_fall");
        end

        tick(2);
        chk("rise_total", rise_seen, exp_rises);
        chk("fall_total", fall_seen, exp_falls);
        chk("rise_fall_overlap", both_seen, 0);
        chk("sb_left", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
